// File: rtl/switch_mcu_regfile.sv
// switch_mcu_regfile
//   Integer register file: two registered read ports, one write port, x0
//   hardwired to zero, plus a sequenced bulk-clear engine that zeroes
//   x1..x(2**ADDR_W-1), one entry per cycle.
//
//   Optional feature macro: SWITCH_MCU_REGFILE_BYPASS_EN
//     defined   : a read to the same nonzero address as a write accepted in
//                 that cycle returns the new write data.
//     undefined : that read returns the old contents; the new value is seen
//                 from the next read onward.
//
//   Handshake: there is no valid/ready flow control. Reads and writes are
//   fire-and-forget enables sampled on every rising edge. in_clr starts a
//   clear only from IDLE; while out_busy=1 it is ignored and every write is
//   refused (out_wr_drop pulses). out_clr_done pulses once at the end.
//
//   out_state is a debug view of the clear FSM (0=IDLE, 1=CLEAR).
module switch_mcu_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_ren_1,
  input  logic [ADDR_W-1:0] in_raddr_1,
  output logic [DATA_W-1:0] out_rdata_1,
  input  logic              in_ren_2,
  input  logic [ADDR_W-1:0] in_raddr_2,
  output logic [DATA_W-1:0] out_rdata_2,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_clr,
  output logic              out_busy,
  output logic              out_clr_done,
  output logic              out_wr_drop,
  output logic              out_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic [DATA_W-1:0] rd_val_1;
  logic [DATA_W-1:0] rd_val_2;

  assign out_state = state;

  // A write lands only from IDLE and never to x0.
  assign wr_ok = in_wen && (state == IDLE) && (in_waddr != '0);

  // Clear FSM: sweeps counter 1..LAST, one entry per cycle, with pulse outputs.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state        <= IDLE;
      counter      <= '0;
      out_busy     <= 1'b0;
      out_clr_done <= 1'b0;
      out_wr_drop  <= 1'b0;
    end else begin
      out_clr_done <= 1'b0;
      out_wr_drop  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_clr) begin
            state    <= CLEAR;
            counter  <= ADDR_W'(1);
            out_busy <= 1'b1;
          end
        end
        CLEAR: begin
          counter     <= counter + 1'b1;
          // A write to x0 is ignored everywhere, so it is not reported as dropped.
          out_wr_drop <= in_wen && (in_waddr != '0);
          if (counter == LAST) begin
            state        <= IDLE;
            counter      <= '0;
            out_busy     <= 1'b0;
            out_clr_done <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          counter  <= '0;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage: accepted writes in IDLE, one-entry sweep in CLEAR; x0 never written.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        regs[in_waddr] <= in_wdata;
      end
      if (state == CLEAR) begin
        regs[counter] <= '0;
      end
    end
  end

  // Port 1 read value, including optional same-cycle write forwarding.
  always_comb begin
    rd_val_1 = (in_raddr_1 == '0) ? '0 : regs[in_raddr_1];
`ifdef SWITCH_MCU_REGFILE_BYPASS_EN
    if (wr_ok && (in_waddr == in_raddr_1)) begin
      rd_val_1 = in_wdata;
    end
`endif
  end

  // Port 2 read value, including optional same-cycle write forwarding.
  always_comb begin
    rd_val_2 = (in_raddr_2 == '0) ? '0 : regs[in_raddr_2];
`ifdef SWITCH_MCU_REGFILE_BYPASS_EN
    if (wr_ok && (in_waddr == in_raddr_2)) begin
      rd_val_2 = in_wdata;
    end
`endif
  end

  // Registered read data; holds when the port is not enabled.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      out_rdata_1 <= '0;
      out_rdata_2 <= '0;
    end else begin
      if (in_ren_1) begin
        out_rdata_1 <= rd_val_1;
      end
      if (in_ren_2) begin
        out_rdata_2 <= rd_val_2;
      end
    end
  end

endmodule
